sr_float_delay: RTL
===================

SR_FLOAT_DELAY -- requirements
Module: sr_float_delay

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 sr_valid  input  1  SR carries a new reconstructed-signal sample this cycle.
REQ-005 SR  input  16  reconstructed signal, two's complement (output of the SR adder stage).
REQ-006 flush  input  1  synchronous clear of pipeline and delay line.
REQ-007 SR1  output  11  floating-point SR delayed one sample: {sign, exp[3:0], mant[5:0]}.
REQ-008 SR2  output  11  floating-point SR delayed two samples, same format.
REQ-009 out_valid  output  1  one-cycle pulse: SR1/SR2 updated on the preceding edge.
REQ-010 primed  output  1  two or more samples have entered the delay line since the last reset or flush.

Function
REQ-011 Conversion SHALL be: sign = SR[15]; MAG = sign ? ((65536 - SR) & 32767) : SR.
REQ-012 EXP SHALL be (bit index of MSB of MAG) + 1, or 0 when MAG = 0; range 0..15, 4 bits.
REQ-013 MANT SHALL be 6'd32 when MAG = 0, else ((MAG << 6) >> EXP) truncated to 6 bits.
REQ-014 The pipeline SHALL have two register stages: stage 1 captures sign and MAG; stage 2 computes EXP/MANT and writes the delay line.
REQ-015 A sample with sr_valid = 1 at edge k SHALL update SR1/SR2 at edge k+2; out_valid SHALL be high in the cycle after edge k+2 only.
REQ-016 Delay-line update SHALL be SR2 <= SR1 and SR1 <= new float, in the same edge.
REQ-017 The pipeline SHALL accept one sample per cycle with no stall; back-to-back sr_valid gives back-to-back out_valid.
REQ-018 With sr_valid = 0, SR is don't-care; stage registers and SR1/SR2 SHALL hold.
REQ-019 An internal 2-bit saturating counter SHALL count delay-line writes; primed = 1 when count = 2; it stays at 2.
REQ-020 flush = 1 at an edge SHALL clear both stage valid bits, set SR1 = SR2 = 11'h020, set count = 0 and primed = 0, and deassert out_valid.
REQ-021 flush with sr_valid in the same cycle SHALL drop the sample.
REQ-022 Samples in flight when flush asserts SHALL never reach SR1/SR2.
REQ-023 SR = 16'h8000 SHALL convert to 11'h420 (MAG masks to 0; sign kept).
REQ-024 No arithmetic overflow SHALL be possible: MAG is at most 15 bits and the shift result fits 6 bits after truncation.

Reset
REQ-025 reset SHALL take priority over flush and sr_valid.
REQ-026 On reset: SR1 = SR2 = 11'h020, out_valid = 0, primed = 0, count = 0, and both stage valid bits = 0.
REQ-027 Reset asserted mid-pipeline SHALL discard all in-flight samples; the first out_valid after reset SHALL come from a sample accepted after reset deasserts.

Verification
REQ-028 Reset, then SR = 16'h0001 valid at edge 1 -> out_valid after edge 3, SR1 = 11'h060, SR2 = 11'h020, primed = 0.
REQ-029 Back-to-back SR = 16'hFFFF, 16'h7FFF, 16'h0040 at edges 1..3 -> SR1 = 11'h460, 11'h3FF, 11'h1E0 on edges 3..5; SR2 = 11'h020, 11'h460, 11'h3FF; out_valid high for 3 consecutive cycles; primed = 1 from edge 4.
REQ-030 SR = 16'h8000 and SR = 16'h0000 -> SR1 = 11'h420 and 11'h020 respectively.
REQ-031 Flush at edge 2 while a sample accepted at edge 1 is in flight, with a simultaneous sr_valid -> no out_valid; SR1 = SR2 = 11'h020; primed = 0.
REQ-032 Random SR (1000 samples, random sr_valid gaps) checked against the REQ-011..013 model -> exact SR1/SR2 match on every out_valid; holds between samples.

Source files
------------

// File: rtl/sr_float_delay.sv
// Converts the reconstructed signal SR to an 11-bit float {sign, exp, mant} and keeps a
// two-sample delay line (SR1, SR2); two register stages, one sample per cycle, no stall.
module sr_float_delay (
  input  logic        clk,
  input  logic        reset,
  input  logic        sr_valid,
  input  logic [15:0] SR,
  input  logic        flush,
  output logic [10:0] SR1,
  output logic [10:0] SR2,
  output logic        out_valid,
  output logic        primed
);

  localparam logic [10:0] FLOAT_ZERO = 11'h020;

  logic        s1_vld;
  logic        s1_sign;
  logic [14:0] s1_mag;
  logic        s2_vld;
  logic [10:0] s2_flt;
  logic [1:0]  wr_cnt;

  logic [14:0] sr_neg;
  logic [14:0] mag_in;
  logic [3:0]  exp_c;
  logic [5:0]  mant_c;

  // Only the low 15 bits of the negation survive, so 16'h8000 folds to magnitude 0.
  assign sr_neg = ~SR[14:0] + 15'd1;
  assign mag_in = SR[15] ? sr_neg : SR[14:0];

  always_comb begin
    exp_c = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (s1_mag[i]) exp_c = 4'(i + 1);
    end
    if (exp_c == 4'd0) mant_c = 6'd32;
    else               mant_c = 6'({s1_mag, 6'b0} >> exp_c);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_vld    <= 1'b0;
      s1_sign   <= 1'b0;
      s1_mag    <= '0;
      s2_vld    <= 1'b0;
      s2_flt    <= FLOAT_ZERO;
      SR1       <= FLOAT_ZERO;
      SR2       <= FLOAT_ZERO;
      out_valid <= 1'b0;
      wr_cnt    <= 2'd0;
    end else begin
      s1_vld <= sr_valid;
      if (sr_valid) begin
        s1_sign <= SR[15];
        s1_mag  <= mag_in;
      end
      s2_vld <= s1_vld;
      if (s1_vld) s2_flt <= {s1_sign, exp_c, mant_c};
      out_valid <= s2_vld;
      if (s2_vld) begin
        SR2 <= SR1;
        SR1 <= s2_flt;
        if (wr_cnt != 2'd2) wr_cnt <= wr_cnt + 2'd1;
      end
    end
  end

  assign primed = (wr_cnt == 2'd2);

endmodule
